// File: rtl/sup_ram_mar.sv
// sup_ram_mar: parametrised RAM with memory address register, post-reset clear sequencer and program-load port
module sup_ram_mar #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 4,
    parameter bit CLEAR_ON_RST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] bus,
    input  logic              mi,
    input  logic              minc,
    input  logic              ri,
    input  logic              ro,
    input  logic              prog_en,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] prog_rdata,
    output logic [ADDR_W-1:0] mar,
    output logic              busy,
    output logic              err
);
    localparam int DEPTH = 2 ** ADDR_W;
    typedef enum logic [1:0] {CLEAR, RUN, PROG} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d, cnt_q, waddr;
    logic              err_q, err_d, clr, run, prog, rd, we;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] mem_q [DEPTH];
    assign clr  = state_q == CLEAR;
    assign run  = state_q == RUN;
    assign prog = state_q == PROG;
    assign rd   = !rst && run && ro;
    assign bus  = rd ? mem_q[mar_q] : 'z;
    // a single write port is shared by the clear sequencer, the bus and the loader
    assign we    = !rst && (clr || (run && ri && !ro) || (prog && prog_valid));
    assign waddr = clr ? cnt_q : prog ? prog_addr : mar_q;
    assign wdata = clr ? '0 : prog ? prog_data : bus;
    assign state_d = clr ? (&cnt_q ? RUN : CLEAR) : prog_en ? PROG : RUN;
    assign mar_d   = run && mi ? bus[ADDR_W-1:0] : run && minc ? mar_q + 1'b1 : mar_q;
    assign err_d   = err_q | (run && ri && ro);
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR_ON_RST ? CLEAR : RUN;
            mar_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            cnt_q   <= clr ? cnt_q + 1'b1 : '0;
            err_q   <= err_d;
        end
    end
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end
    assign busy       = rst ? CLEAR_ON_RST : clr;
    assign prog_ready = !rst && prog;
    assign prog_rdata = mem_q[prog_addr];
    assign mar        = mar_q;
    assign err        = err_q;
endmodule
